iter_multiplier: RTL and testbench

ITER_MULTIPLIER -- requirements
Module: iter_multiplier

---
 rtl/iter_multiplier.sv | 107 ++++++++++
 tb/tb_iter_multiplier.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/iter_multiplier.sv
// Iterative shift-add multiplier for MUL / MULH / MULHSU / MULHU.
// Handles one operation at a time: WIDTH add-shift cycles, one sign-fix cycle, then a valid/ready result.
module iter_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [1:0]       i_op,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     a_mag_q, a_mag_d;
    logic                 a_neg_q, a_neg_d;
    logic                 b_neg_q, b_neg_d;
    logic [1:0]           op_q, op_d;
    logic [WIDTH:0]       sum;
    logic                 a_neg_in, b_neg_in;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        a_mag_d  = a_mag_q;
        a_neg_d  = a_neg_q;
        b_neg_d  = b_neg_q;
        op_d     = op_q;
        a_neg_in = ((i_op == 2'b01) || (i_op == 2'b10)) && i_a[WIDTH-1];
        b_neg_in = (i_op == 2'b01) && i_b[WIDTH-1];
        // Extra bit keeps the carry out of the partial-product add before the shift.
        sum      = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_mag_q} : '0);

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    op_d    = i_op;
                    a_neg_d = a_neg_in;
                    b_neg_d = b_neg_in;
                    a_mag_d = a_neg_in ? -i_a : i_a;
                    prod_d  = {{WIDTH{1'b0}}, (b_neg_in ? -i_b : i_b)};
                end
            end
            CALC: begin
                prod_d = {sum, prod_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (a_neg_q ^ b_neg_q) begin
                    prod_d = -prod_q;
                end
                state_d = DONE;
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            a_mag_q <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            op_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            a_mag_q <= a_mag_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            op_q    <= op_d;
        end
    end

    assign o_ready  = (state_q == IDLE);
    assign o_busy   = (state_q != IDLE);
    assign o_valid  = (state_q == DONE);
    assign o_result = (op_q == 2'b00) ? prod_q[WIDTH-1:0] : prod_q[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_iter_multiplier.sv
// Self-checking bench for iter_multiplier (WIDTH=32): directed corner cases, backpressure,
// mid-operation reset, and randomized ops compared against a 64-bit arithmetic reference.
module tb_iter_multiplier;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic [1:0]   i_op;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_result;
    logic         o_busy;

    int n_vec  = 0;
    int n_fail = 0;

    iter_multiplier #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_op     (i_op),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_busy   (o_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full-precision product of the operands interpreted per op, then pick the requested half.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
        logic        sa;
        logic        sb;
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        sa = (op == 2'b01 || op == 2'b10) && a[31];
        sb = (op == 2'b01) && b[31];
        ea = {{32{sa}}, a};
        eb = {{32{sb}}, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Issue one request (inputs change at negedges), hold the result for `stall` extra cycles.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                          input logic [31:0] exp, input int stall, input string tag);
        int lat;
        check({tag, "_ready_idle"}, o_ready, 1);
        i_valid = 1'b1;
        i_a     = a;
        i_b     = b;
        i_op    = op;
        i_ready = (stall == 0);
        @(negedge clk);
        i_valid = 1'b0;
        i_a     = $urandom;
        i_b     = $urandom;
        i_op    = 2'($urandom_range(0, 3));
        lat = 1;
        while (!o_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        // Edges counted include the accept edge itself.
        check({tag, "_latency"}, lat, W + 2);
        check({tag, "_result"}, o_result, exp);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, o_valid, 1);
            check({tag, "_hold_result"}, o_result, exp);
            check({tag, "_hold_ready"}, o_ready, 0);
        end
        i_ready = 1'b1;
        @(negedge clk);
        check({tag, "_valid_drop"}, o_valid, 0);
        check({tag, "_ready_back"}, o_ready, 1);
        i_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  rop;
        logic [31:0] corner [5];
        corner[0] = 32'h0000_0000;
        corner[1] = 32'h0000_0001;
        corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000;
        corner[4] = 32'h7FFF_FFFF;

        rst_n   = 1'b0;
        i_valid = 1'b1;
        i_a     = 32'h1234_5678;
        i_b     = 32'h9ABC_DEF0;
        i_op    = 2'b11;
        i_ready = 1'b0;

        // Reset held two edges with a request pending: nothing may be accepted.
        repeat (2) begin
            @(negedge clk);
            check("rst_busy", o_busy, 0);
        end
        check("rst_ready", o_ready, 1);
        check("rst_valid", o_valid, 0);
        check("rst_result", o_result, 0);
        i_valid = 1'b0;
        rst_n   = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("idle_stays_idle", o_busy, 0);
        end

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'hFFFF_FFFE, 0, "mulhu_max");
        run_op(32'hFFFF_FFF9, 32'h0000_0003, 2'b00, 32'hFFFF_FFEB, 0, "mul_neg7x3");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'h0000_0001, 0, "mul_max");
        run_op(32'h8000_0000, 32'h8000_0000, 2'b01, 32'h4000_0000, 0, "mulh_minmin");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 32'hFFFF_FFFF, 0, "mulhsu_m1");
        run_op(32'h0000_0000, 32'h8000_0000, 2'b01, 32'h0000_0000, 0, "mulh_zero");
        run_op(32'h8000_0000, 32'h0000_0000, 2'b10, 32'h0000_0000, 1, "mulhsu_zero");
        run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 2'b01, ref_mul(32'hDEAD_BEEF, 32'h0BAD_F00D, 2'b01),
               10, "backpressure");

        // Abort an op after 15 CALC iterations; the request line stays high throughout.
        i_valid = 1'b1;
        i_a     = 32'hFFFF_FFFF;
        i_b     = 32'hFFFF_FFFF;
        i_op    = 2'b11;
        i_ready = 1'b1;
        @(negedge clk);
        repeat (15) @(negedge clk);
        check("abort_busy_before", o_busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_valid", o_valid, 0);
        check("abort_ready", o_ready, 1);
        check("abort_busy", o_busy, 0);
        check("abort_result", o_result, 0);
        rst_n = 1'b1;
        run_op(32'h0000_0007, 32'hFFFF_FFFA, 2'b01, 32'hFFFF_FFFF, 0, "after_abort");

        for (int n = 0; n < 1000; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            run_op(ra, rb, rop, ref_mul(ra, rb, rop), $urandom_range(0, 3), "rand");
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check("rand_gap_idle", o_busy, 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
